// File: rtl/persiana_pkg.sv
// Shared types and helpers for the blind controller blocks: FSM state encoding,
// light-sensor codes and small one-hot utilities used on sensor/command vectors.
package persiana_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        FAULT     = 2'd3
    } state_t;

    localparam logic [1:0] LIGHT_OPEN     = 2'b00;
    localparam logic [1:0] LIGHT_MID      = 2'b01;
    localparam int         LIGHT_DARK_BIT = 1;

    // Helpers take a zero-extended vector so one definition serves any N_POS.
    localparam int MAX_VEC_W = 64;

    function automatic logic at_most_one(input logic [MAX_VEC_W-1:0] v);
        return (v & (v - {{(MAX_VEC_W-1){1'b0}}, 1'b1})) == '0;
    endfunction

    function automatic int onehot_idx(input logic [MAX_VEC_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_VEC_W; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/persiana_ctrl_multipos_if.sv
// Board-side bundle of the blind controller: user command, sensors in,
// motor/fault/debug indications out.
interface persiana_ctrl_multipos_if #(
    parameter int N_POS = 3
);
    localparam int POS_W = (N_POS > 1) ? $clog2(N_POS) : 1;

    logic [N_POS:0]   cmd;
    logic [N_POS-1:0] pos_sens;
    logic [1:0]       light;
    logic             up;
    logic             down;
    logic             fault;
    logic             tick;
    logic [POS_W-1:0] pos;

    modport master (
        output cmd, pos_sens, light,
        input  up, down, fault, tick, pos
    );

    modport slave (
        input  cmd, pos_sens, light,
        output up, down, fault, tick, pos
    );
endinterface

// File: rtl/persiana_tick_gen.sv
// Free-running prescaler producing a one-clock enable pulse every
// 2^PRESCALE_W cycles, while the counter is all-ones.
module persiana_tick_gen #(
    parameter int PRESCALE_W = 25
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick_o = &cnt_q;
endmodule

// File: rtl/persiana_ctrl_multipos.sv
// Blind controller: drives the motor toward a commanded or light-selected
// position among N_POS sensors, with a move watchdog and latched sensor fault.
module persiana_ctrl_multipos
    import persiana_pkg::*;
#(
    parameter int N_POS         = 3,
    parameter int PRESCALE_W    = 25,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic                     clk,
    input  logic                     btnC,
    persiana_ctrl_multipos_if.slave  bus
);
    localparam int POS_W = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    logic             tick;
    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             fault_q, fault_d;
    logic [POS_W-1:0] target;
    logic             sens_one;
    logic             sens_conflict;

    persiana_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .clk    (clk),
        .rst    (btnC),
        .tick_o (tick)
    );

    // An invalid command (none or several bits) holds the current position.
    always_comb begin
        target = pos_q;
        if ((|bus.cmd) && at_most_one(MAX_VEC_W'(bus.cmd))) begin
            if (bus.cmd[N_POS]) begin
                if (bus.light[LIGHT_DARK_BIT])  target = '0;
                else if (bus.light == LIGHT_MID) target = POS_W'(N_POS / 2);
                else                             target = POS_W'(N_POS - 1);
            end else begin
                target = POS_W'(onehot_idx(MAX_VEC_W'(bus.cmd)));
            end
        end
    end

    assign sens_one      = (|bus.pos_sens) && at_most_one(MAX_VEC_W'(bus.pos_sens));
    assign sens_conflict = !at_most_one(MAX_VEC_W'(bus.pos_sens));
    assign cnt_inc       = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (sens_one) pos_d = POS_W'(onehot_idx(MAX_VEC_W'(bus.pos_sens)));
            if (sens_conflict) begin
                state_d = FAULT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (target > pos_q) begin
                            state_d = MOVE_UP;
                            cnt_d   = '0;
                        end else if (target < pos_q) begin
                            state_d = MOVE_DOWN;
                            cnt_d   = '0;
                        end
                    end
                    // Reaching or losing the target outranks the watchdog.
                    MOVE_UP: begin
                        if (bus.pos_sens[target] || (target <= pos_q)) state_d = IDLE;
                        else if (cnt_inc >= CNT_W'(TIMEOUT_TICKS))      state_d = FAULT;
                        else                                            cnt_d   = cnt_inc;
                    end
                    MOVE_DOWN: begin
                        if (bus.pos_sens[target] || (target >= pos_q)) state_d = IDLE;
                        else if (cnt_inc >= CNT_W'(TIMEOUT_TICKS))      state_d = FAULT;
                        else                                            cnt_d   = cnt_inc;
                    end
                    FAULT: state_d = FAULT;
                    default: state_d = FAULT;
                endcase
            end
        end
    end

    assign up_d    = (state_d == MOVE_UP);
    assign down_d  = (state_d == MOVE_DOWN);
    assign fault_d = (state_d == FAULT);

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            state_q <= IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            down_q  <= down_d;
            fault_q <= fault_d;
        end
    end

    assign bus.up    = up_q;
    assign bus.down  = down_q;
    assign bus.fault = fault_q;
    assign bus.tick  = tick;
    assign bus.pos   = pos_q;
endmodule

// File: tb/tb_persiana_ctrl_multipos.sv
// Scenario bench for persiana_ctrl_multipos with N_POS=4, PRESCALE_W=2, TIMEOUT_TICKS=5.
module tb_persiana_ctrl_multipos;

    typedef struct packed {
        logic [3:0] sens;
        logic [4:0] cmd;
        logic [1:0] light;
        logic [4:0] exp;   // {up, down, fault, pos[1:0]}
    } step_t;

    logic clk;
    logic btnC;
    int   n_checks;
    int   n_fail;
    logic [4:0] sb_q[$];

    persiana_ctrl_multipos_if #(.N_POS(4)) bus ();

    persiana_ctrl_multipos #(
        .N_POS(4),
        .PRESCALE_W(2),
        .TIMEOUT_TICKS(5)
    ) dut (
        .clk  (clk),
        .btnC (btnC),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: tick=0 for 16 clks, required tick=1");
        end
    endtask

    task automatic apply_reset();
        bus.cmd      = '0;
        bus.pos_sens = '0;
        bus.light    = '0;
        @(negedge clk);
        btnC = 1'b1;
        @(negedge clk);
        @(negedge clk);
        btnC = 1'b0;
    endtask

    task automatic test_reset();
        int  gap;
        bit  ok;
        logic [4:0] e;
        logic [4:0] got;
        bus.cmd = '0; bus.pos_sens = '0; bus.light = '0;
        @(negedge clk);
        btnC = 1'b1;
        #1;
        n_checks++;
        got = {bus.up, bus.down, bus.fault, bus.pos};
        if (got !== 5'b00000 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got up/down/fault/pos=%b tick=%b required 00000 tick=0", got, bus.tick);
        end
        @(negedge clk);
        btnC = 1'b0;
        gap = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            gap++;
            if (bus.tick) break;
        end
        n_checks++;
        if (gap !== 3) begin
            n_fail++;
            $display("FAIL first_tick: got %0d clks after release, required 3", gap);
        end
        @(negedge clk);
        n_checks++;
        if (bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_width: got tick=%b one clk after pulse, required 0", bus.tick);
        end
        gap = 1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            gap++;
            if (bus.tick) break;
        end
        n_checks++;
        if (gap !== 4) begin
            n_fail++;
            $display("FAIL tick_period: got %0d clks, required 4", gap);
        end
        sb_q.push_back(5'b00000);
        wait_tick(ok);
        e = sb_q.pop_front();
        if (ok) begin
            n_checks++;
            got = {bus.up, bus.down, bus.fault, bus.pos};
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_idle: got up/down/fault/pos=%b required %b", got, e);
            end
        end
    endtask

    task automatic test_move_up();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [5] = '{
            '{4'b0001, 5'b01000, 2'b00, 5'b10000},
            '{4'b0010, 5'b01000, 2'b00, 5'b10001},
            '{4'b0000, 5'b01000, 2'b00, 5'b10001},
            '{4'b1000, 5'b01000, 2'b00, 5'b00011},
            '{4'b1000, 5'b01000, 2'b00, 5'b00011}
        };
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL move_up[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
            end
        end
    endtask

    task automatic test_auto_down();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [7] = '{
            '{4'b1000, 5'b10000, 2'b01, 5'b01011},
            '{4'b0000, 5'b10000, 2'b10, 5'b01011},
            '{4'b0100, 5'b10000, 2'b10, 5'b01010},
            '{4'b0000, 5'b10000, 2'b10, 5'b01010},
            '{4'b0001, 5'b10000, 2'b10, 5'b00000},
            '{4'b0001, 5'b10000, 2'b00, 5'b10000},
            '{4'b1000, 5'b10000, 2'b00, 5'b00011}
        };
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL auto_down[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
            end
        end
    endtask

    task automatic test_reversal();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [8] = '{
            '{4'b0001, 5'b01000, 2'b00, 5'b10000},
            '{4'b0010, 5'b01000, 2'b00, 5'b10001},
            '{4'b0000, 5'b00001, 2'b00, 5'b00001},
            '{4'b0000, 5'b00001, 2'b00, 5'b01001},
            '{4'b0001, 5'b00001, 2'b00, 5'b00000},
            '{4'b0001, 5'b00100, 2'b00, 5'b10000},
            '{4'b0000, 5'b00110, 2'b00, 5'b00000},
            '{4'b0000, 5'b00000, 2'b00, 5'b00000}
        };
        apply_reset();
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL reversal_hold[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
                if (bus.up && bus.down) begin
                    n_fail++;
                    $display("FAIL up_down_exclusive[%0d]: got up=1 down=1, required not both", i);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [7] = '{
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b00100},
            '{4'b0001, 5'b00001, 2'b00, 5'b00100}
        };
        apply_reset();
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL timeout[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
            end
        end
        #2;
        btnC = 1'b1;
        #1;
        n_checks++;
        got = {bus.up, bus.down, bus.fault, bus.pos};
        if (got !== 5'b00000) begin
            n_fail++;
            $display("FAIL fault_clear: got up/down/fault/pos=%b required 00000", got);
        end
        @(negedge clk);
        btnC = 1'b0;
    endtask

    task automatic test_timeout_race();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [6] = '{
            '{4'b0001, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b0000, 5'b01000, 2'b00, 5'b10000},
            '{4'b1000, 5'b01000, 2'b00, 5'b00011}
        };
        apply_reset();
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL timeout_race[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
            end
        end
    endtask

    task automatic test_conflict();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [3] = '{
            '{4'b0001, 5'b01000, 2'b00, 5'b10000},
            '{4'b0101, 5'b01000, 2'b00, 5'b00100},
            '{4'b0001, 5'b00000, 2'b00, 5'b00100}
        };
        apply_reset();
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL conflict[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_move();
        bit ok;
        logic [4:0] e;
        logic [4:0] got;
        step_t tbl [2] = '{
            '{4'b0001, 5'b01000, 2'b00, 5'b10000},
            '{4'b0010, 5'b01000, 2'b00, 5'b10001}
        };
        apply_reset();
        foreach (tbl[i]) begin
            bus.pos_sens = tbl[i].sens; bus.cmd = tbl[i].cmd; bus.light = tbl[i].light;
            sb_q.push_back(tbl[i].exp);
            wait_tick(ok);
            e = sb_q.pop_front();
            if (ok) begin
                n_checks++;
                got = {bus.up, bus.down, bus.fault, bus.pos};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL mid_move[%0d]: got up/down/fault/pos=%b required %b", i, got, e);
                end
            end
        end
        #2;
        btnC = 1'b1;
        #1;
        n_checks++;
        got = {bus.up, bus.down, bus.fault, bus.pos};
        if (got !== 5'b00000 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got up/down/fault/pos=%b tick=%b required 00000 tick=0", got, bus.tick);
        end
        @(negedge clk);
        btnC = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        btnC     = 1'b0;
        bus.cmd = '0; bus.pos_sens = '0; bus.light = '0;
        test_reset();
        test_move_up();
        test_auto_down();
        test_reversal();
        test_timeout();
        test_timeout_race();
        test_conflict();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000 ns, required finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/persiana_ctrl_multipos.md
# persiana_ctrl_multipos

Parametrised blind (persiana) controller. It drives a motor up or down until the blind reaches a commanded or automatically selected position, and supports N position sensors instead of three fixed ones. The whole block runs in a single clock domain and uses a prescaler tick-enable rather than a derived clock. It adds a movement watchdog, sensor-consistency checking and a latched fault state. It sits between the board switches/sensors and the motor-drive LEDs at the top level.

## Interface
Parameters:
- `N_POS`, 3: number of discrete positions/sensors. Position 0 = fully closed (bottom); position N_POS-1 = fully open. Minimum 2.
- `PRESCALE_W`, 25: prescaler width. One tick every 2^PRESCALE_W clk cycles.
- `TIMEOUT_TICKS`, 16: maximum ticks allowed in a move before fault. Minimum 2.

Ports:
- `clk`  in  1  system clock (100 MHz on board).
- `btnC`  in  1  reset, asynchronous, active-high.
- `cmd`  in  N_POS+1  one-hot user command. Bit i (i<N_POS) = go to position i; bit N_POS = automatic mode.
- `pos_sens`  in  N_POS  position sensors; bit i high while the blind is at position i.
- `light`  in  2  light sensor. 00 → open (N_POS-1); 01 → middle (N_POS/2, integer division); 1x → closed (0).
- `up`  out  1  motor raise.
- `down`  out  1  motor lower.
- `fault`  out  1  latched fault indicator.
- `tick`  out  1  one-clk prescaler pulse (debug/LED stretch external).
- `pos`  out  $clog2(N_POS)  last confirmed position.

## Operation
- Prescaler: free-running PRESCALE_W-bit counter. `tick`=1 during the cycle in which the counter is all-ones.
- All FSM, command and position registers update only on clk edges where `tick`=1.
- Command decode on each tick:
  - Exactly one bit of `cmd` set: bit i gives target i; bit N_POS gives the target from `light`.
  - Zero or more than one bit set: target = `pos` (stop/hold).
- Position tracking on each tick:
  - Exactly one `pos_sens` bit set: `pos` ← that index.
  - Zero bits set: hold `pos` (the blind is between positions).
  - Two or more bits set: go to FAULT.
- States:
  - IDLE: if target>`pos`, go to MOVE_UP; if target<`pos`, go to MOVE_DOWN; otherwise stay.
  - MOVE_UP: if `pos_sens[target]`, go to IDLE. If the target drops to `pos` or below, go to IDLE (stop one tick before any reversal). Otherwise keep moving.
  - MOVE_DOWN: mirror of MOVE_UP.
  - FAULT: absorbing; leaves only on `btnC`.
- Watchdog: move counter clears on entry to MOVE_UP/MOVE_DOWN and increments each tick in a move state. When the count reaches TIMEOUT_TICKS without reaching the target, go to FAULT.
- Direct MOVE_UP↔MOVE_DOWN transitions are forbidden. `up` and `down` are never high together.
- Outputs are registered decodes of the state: `up`=MOVE_UP, `down`=MOVE_DOWN, `fault`=FAULT. In FAULT, both motor outputs are 0.

## Timing
- Reset values: `up`=0, `down`=0, `fault`=0, `tick`=0, `pos`=0, state IDLE, prescaler 0, move counter 0.
- First `tick` occurs 2^PRESCALE_W-1 cycles after reset release.
- Latency: inputs are sampled at a tick edge; `up`/`down`/`fault`/`pos` change on that same edge and are visible the following cycle. There is no extra pipeline stage.
- Inputs are assumed stable across the sampling edge; synchronisers are external.
- Reset mid-move: motor outputs drop asynchronously, immediately.
- Simultaneous target reached and timeout on the same tick: reaching the target wins (go to IDLE).
- A sensor conflict takes priority over all other transitions.

## Structure
- Shared package `persiana_pkg` holds:
  - state enum: IDLE, MOVE_UP, MOVE_DOWN, FAULT;
  - light-code constants;
  - one-hot-to-index and popcount-≤1 helper functions.
- Sub-module `persiana_tick_gen`, parameter PRESCALE_W: counter plus `tick` output; reused by other board blocks.
- The FSM, target decode and watchdog stay in the top module.

## Test plan
All scenarios use PRESCALE_W=2, N_POS=4, TIMEOUT_TICKS=5.
- Reset, then `cmd`=00000: `up`/`down`/`fault`=0; `pos`=0; `tick` pulses every 4 clks.
- `pos_sens`=0001, `cmd`=01000 (go to 3): `up`=1 after the first tick. Sensors step 0000→0010→0000→1000 over successive ticks; `up` drops on the tick that sees 1000 and `pos`=3.
- At `pos`=3, `cmd`=10000 with `light`=01: target 2, `down`=1. `light`=10 mid-move: target 0, still down. Reaching `pos_sens`=0001 → IDLE, `pos`=0.
- Moving up to 3, `cmd` switches to 00001: one tick with `up`=`down`=0 (IDLE), then `down`=1.
- `cmd`=01000 with `pos_sens` stuck at 0000: after 5 ticks `fault`=1 and `up`=0; `fault` persists until `btnC`.
- `pos_sens`=0101 at any tick → `fault`=1. `btnC` pulsed mid-move → `up`=0 in the same cycle and all outputs at their reset values.
